// File: rtl/stage3_mem_if.sv
// stage3_mem_if: request/response bundle between stage2, the memory stage and writeback
interface stage3_mem_if #(parameter int ADDR_W = 9);
  logic              req_valid;
  logic              req_ready;
  logic              req_instr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  modport master (output req_valid, req_instr, req_addr, req_wdata, req_wstrb, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_instr, req_addr, req_wdata, req_wstrb, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/stage3_mem.sv
// stage3_mem: memory-access stage with local word RAM and an in-order response buffer
module stage3_mem #(
  parameter int    ADDR_W    = 9,
  parameter int    OUT_DEPTH = 2,
  parameter string INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  stage3_mem_if.slave bus,
  output logic       trap
);
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int PW    = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW    = $clog2(OUT_DEPTH + 1);
  logic [31:0]          mem [WORDS];
  logic [31:0]          data_q [OUT_DEPTH];
  logic [31:0]          rd_q;
  logic [OUT_DEPTH-1:0] err_q, done_q;
  logic [PW-1:0]        wp_q, rp_q, slot_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, trap_q;
  logic                 acc, pop, is_rd, is_err;
  logic [ADDR_W-3:0]    idx;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign idx           = bus.req_addr[ADDR_W-1:2];
  assign is_rd         = bus.req_wstrb == 4'b0000;
  assign is_err        = is_rd ? (bus.req_addr[1:0] != 2'b00) : bus.req_instr;
  assign bus.req_ready = !trap_q && (cnt_q < CW'(OUT_DEPTH));
  assign acc           = bus.req_valid && bus.req_ready;
  // A slot is reserved at accept; reads mark it done only when their data lands.
  assign bus.rsp_valid = (cnt_q != '0) && done_q[rp_q];
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? data_q[rp_q] : '0;
  assign bus.rsp_err   = bus.rsp_valid && err_q[rp_q];
  assign cnt_d         = cnt_q + CW'(acc) - CW'(pop);
  assign trap          = trap_q;
  always_ff @(posedge clk) begin
    if (acc && !is_err && !is_rd)
      for (int b = 0; b < 4; b++)
        if (bus.req_wstrb[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
    if (acc && !is_err && is_rd) rd_q <= mem[idx];
    if (acc && !(is_rd && !is_err)) data_q[wp_q] <= '0;
    if (pend_q) data_q[slot_q] <= rd_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      slot_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      trap_q <= 1'b0;
      err_q  <= '0;
      done_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= acc && is_rd && !is_err;
      if (pend_q) done_q[slot_q] <= 1'b1;
      if (acc) begin
        wp_q         <= nxt(wp_q);
        slot_q       <= wp_q;
        done_q[wp_q] <= !(is_rd && !is_err);
        err_q[wp_q]  <= is_err;
        trap_q       <= trap_q || is_err;
      end
      if (pop) rp_q <= nxt(rp_q);
    end
  end
endmodule
